// File: rtl/gf180mcu_osu_sc_12t_clkdiv_ctl.sv
// Glitch-free programmable clock divider with period-aligned stop/start and divisor update.
// Define CLKDIV_SYNC_EN to pass EN through a two-flop synchronizer before use.
module gf180mcu_osu_sc_12t_clkdiv_ctl #(
    parameter int WIDTH     = 4,
    parameter int RESET_DIV = 0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             LOAD,
    output logic             Y,
    output logic             TICK,
    output logic             BUSY,
    output logic             ACTIVE
);

    localparam int CW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic             en_s;
    logic [CW-1:0]    cnt_nxt;
    logic             at_wrap;
    logic             high_nxt;

    // Last count of a period: P-1 = D+1, held in WIDTH+1 bits so D=2^WIDTH-1 cannot overflow.
    function automatic logic [CW-1:0] period_last(input logic [WIDTH-1:0] d);
        return {1'b0, d} + CW'(1);
    endfunction

    function automatic logic [CW-1:0] half_period(input logic [WIDTH-1:0] d);
        logic [CW-1:0] p;
        p = {1'b0, d} + CW'(2);
        return p >> 1;
    endfunction

`ifdef CLKDIV_SYNC_EN
    logic [1:0] en_sync;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            en_sync <= 2'b00;
        end else begin
            en_sync <= {en_sync[0], EN};
        end
    end

    assign en_s = en_sync[1];
`else
    assign en_s = EN;
`endif

    assign cnt_nxt  = cnt + CW'(1);
    assign at_wrap  = (cnt >= period_last(div_act));
    assign high_nxt = (cnt_nxt < half_period(div_act));

    // Pending divisor only captured while running; in IDLE LOAD writes the active divisor.
    always_ff @(posedge CLK) begin
        if (LOAD && (state != IDLE)) begin
            div_pend <= DIV;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= WIDTH'(RESET_DIV);
            BUSY    <= 1'b0;
            Y       <= 1'b0;
            TICK    <= 1'b0;
            ACTIVE  <= 1'b0;
        end else begin
            TICK <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (LOAD) begin
                        div_act <= DIV;
                        BUSY    <= 1'b0;
                    end else if (BUSY) begin
                        div_act <= div_pend;
                        BUSY    <= 1'b0;
                    end
                    if (en_s) begin
                        state  <= RUN;
                        Y      <= 1'b1;
                        TICK   <= 1'b1;
                        ACTIVE <= 1'b1;
                    end else begin
                        Y      <= 1'b0;
                        ACTIVE <= 1'b0;
                    end
                end
                default: begin
                    if (at_wrap) begin
                        // Period boundary: the only point where D changes or the clock stops.
                        cnt <= '0;
                        if (BUSY) begin
                            div_act <= div_pend;
                        end
                        BUSY <= LOAD;
                        if ((state == RUN) && en_s) begin
                            Y      <= 1'b1;
                            TICK   <= 1'b1;
                            ACTIVE <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            Y      <= 1'b0;
                            ACTIVE <= 1'b0;
                        end
                    end else begin
                        cnt    <= cnt_nxt;
                        Y      <= high_nxt;
                        ACTIVE <= 1'b1;
                        state  <= en_s ? RUN : DRAIN;
                        if (LOAD) begin
                            BUSY <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv_ctl.sv
// Directed bench for the clock divider controller; outputs checked as {Y,TICK,BUSY,ACTIVE}.
module tb_gf180mcu_osu_sc_12t_clkdiv_ctl;

    logic       clk;
    logic       rn;
    logic       en;
    logic [3:0] div;
    logic       load;
    logic       y;
    logic       tick;
    logic       busy;
    logic       active;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef CLKDIV_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    gf180mcu_osu_sc_12t_clkdiv_ctl #(
        .WIDTH     (4),
        .RESET_DIV (0)
    ) dut (
        .CLK    (clk),
        .RN     (rn),
        .EN     (en),
        .DIV    (div),
        .LOAD   (load),
        .Y      (y),
        .TICK   (tick),
        .BUSY   (busy),
        .ACTIVE (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {y, tick, busy, active};
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed={Y,TICK,BUSY,ACTIVE}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp);
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    task automatic sync_wait(input string tag);
        for (int i = 0; i < SYNC_LAT; i++) step(tag, 4'b0000);
    endtask

    initial begin
        rn   = 1'b1;
        en   = 1'b0;
        div  = 4'd0;
        load = 1'b0;
        #1 rn = 1'b0;
        #1 chk("reset_async", 4'b0000);
        repeat (2) @(posedge clk);
        #1 rn = 1'b1;
        step("idle_after_reset", 4'b0000);

        // P=2 from reset divisor
        en = 1'b1;
        sync_wait("p2_sync");
        step("p2_c0", 4'b1101);
        step("p2_c1", 4'b0001);
        step("p2_c2", 4'b1101);
        step("p2_c3", 4'b0001);
        en = 1'b0;
        step("p2_stop", 4'b0000);
        step("p2_idle", 4'b0000);

        // IDLE load DIV=1 -> P=3
        load = 1'b1; div = 4'd1;
        step("p3_load_idle", 4'b0000);
        load = 1'b0; en = 1'b1;
        step("p3_c0", 4'b1101);
        step("p3_c1", 4'b0001);
        step("p3_c2", 4'b0001);
        step("p3_c3", 4'b1101);
        step("p3_c4", 4'b0001);
        step("p3_c5", 4'b0001);
        en = 1'b0;
        step("p3_stop", 4'b0000);

        // P=4 running, load DIV=4 at cnt=1 -> P=6 after wrap
        load = 1'b1; div = 4'd2;
        step("p4_load_idle", 4'b0000);
        load = 1'b0; en = 1'b1;
        step("p4_c0", 4'b1101);
        step("p4_c1", 4'b1001);
        load = 1'b1; div = 4'd4;
        step("p4_c2_busy", 4'b0011);
        load = 1'b0;
        step("p4_c3_busy", 4'b0011);
        step("p6_c0", 4'b1101);
        step("p6_c1", 4'b1001);
        step("p6_c2", 4'b1001);
        step("p6_c3", 4'b0001);
        step("p6_c4", 4'b0001);
        step("p6_c5", 4'b0001);
        step("p6_c0b", 4'b1101);

        // Drop EN at cnt=1: period completes, then IDLE
        step("drain_c1", 4'b1001);
        en = 1'b0;
        step("drain_c2", 4'b1001);
        step("drain_c3", 4'b0001);
        step("drain_c4", 4'b0001);
        step("drain_c5", 4'b0001);
        step("drain_idle", 4'b0000);
        step("drain_idle2", 4'b0000);

        // Drop EN at cnt=1, re-raise at cnt=3: no gap, no phase jump
        en = 1'b1;
        step("rerun_c0", 4'b1101);
        step("rerun_c1", 4'b1001);
        en = 1'b0;
        step("rerun_c2", 4'b1001);
        step("rerun_c3", 4'b0001);
        en = 1'b1;
        step("rerun_c4", 4'b0001);
        step("rerun_c5", 4'b0001);
        step("rerun_wrap", 4'b1101);
        step("rerun_c1b", 4'b1001);

        // Async reset mid-period with a pending divisor
        load = 1'b1; div = 4'd0;
        step("rst_c2_busy", 4'b1011);
        load = 1'b0;
        #2 rn = 1'b0;
        #1 chk("rst_midperiod", 4'b0000);
        step("rst_held", 4'b0000);
        rn = 1'b1;
        sync_wait("rst_sync");
        step("rst_restart_c0", 4'b1101);
        step("rst_restart_c1", 4'b0001);
        step("rst_restart_c2", 4'b1101);
        en = 1'b0;
        step("rst_drain", 4'b0001);
        step("rst_idle", 4'b0000);

        // P=17: 8 high, 9 low; LOAD on the wrap cycle
        load = 1'b1; div = 4'd15;
        step("p17_load", 4'b0000);
        load = 1'b0; en = 1'b1;
        step("p17_c0", 4'b1101);
        for (int c = 1; c <= 7; c++) step("p17_hi", 4'b1001);
        for (int c = 8; c <= 15; c++) step("p17_lo", 4'b0001);
        load = 1'b1; div = 4'd0;
        step("p17_c16_busy", 4'b0011);
        div = 4'd1;
        step("wrapload_c0", 4'b1111);
        load = 1'b0;
        step("wrapload_c1", 4'b0011);
        step("wrapload_apply", 4'b1101);
        step("p3b_c1", 4'b0001);
        step("p3b_c2", 4'b0001);
        step("p3b_c0", 4'b1101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
